alu_seq: RTL and testbench

Command sequencer sitting between the CPU execute stage and the combinational `ALU`. It accepts one arithmetic/logic command per handshake and drives the ALU operand, op and carry inputs. For 16-bit commands (DPTR arithmetic, 16-bit add/subtract) it chains two ALU passes, propagating carry from the low pass to the high pass. It returns the 8- or 16-bit result and final carry on a held valid/ready result port.

---
 rtl/mcu51_pkg.sv | 43 ++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu51_pkg.sv
// Shared MCU51 definitions: ALU op codes, the sequencer state type and the
// helpers that decide how a 16-bit command is split into two ALU passes.
package mcu51_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADDC = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_INC  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_DEC  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SUBB = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_DA   = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_ANL  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_ORL  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_XRL  = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_CPL  = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_CLR  = 5'd12;
    localparam logic [ALU_OP_W-1:0] ALU_RL   = 5'd13;
    localparam logic [ALU_OP_W-1:0] ALU_RLC  = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_RR   = 5'd15;
    localparam logic [ALU_OP_W-1:0] ALU_RRC  = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_SWAP = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_XCHD = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P_LO = 2'd1,
        ST_P_HI = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    function automatic logic is_wide_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_ADDC) || (op == ALU_SUBB);
    endfunction

    // The high pass must always consume the low-pass carry, so ADD becomes ADDC.
    function automatic logic [ALU_OP_W-1:0] hi_pass_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SUBB) ? ALU_SUBB : ALU_ADDC;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Command sequencer in front of the combinational ALU: one or two byte passes
// per command, result held on a valid/ready port until consumed.
module alu_seq
    import mcu51_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic                clk,
    input  logic                rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // cmd_ready is high only in IDLE; res_valid is held with stable data
    // until res_ready is seen, and res_ready outside DONE is ignored.
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [2*DATA_W-1:0] cmd_a,
    input  logic [2*DATA_W-1:0] cmd_b,
    input  logic                cmd_cin,
    input  logic                cmd_wide,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*DATA_W-1:0] res_data,
    output logic                res_cy,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_a_data,
    output logic [DATA_W-1:0]   alu_b_data,
    output logic                alu_c_in,
    input  logic [DATA_W-1:0]   alu_ans,
    input  logic                alu_c_out,
    output logic [1:0]          dbg_state_o
);

    seq_state_e          state_q;
    logic [OP_W-1:0]     op_q;
    logic [2*DATA_W-1:0] a_q;
    logic [2*DATA_W-1:0] b_q;
    logic                cin_q;
    logic                wide_q;
    logic                cy_q;
    logic                cmd_ready_q;
    logic                res_valid_q;
    logic [2*DATA_W-1:0] res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            wide_q      <= 1'b0;
            cy_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        cin_q       <= cmd_cin;
                        wide_q      <= cmd_wide;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_P_LO;
                    end
                end
                ST_P_LO: begin
                    res_q <= {{DATA_W{1'b0}}, alu_ans};
                    cy_q  <= alu_c_out;
                    if (wide_q && is_wide_op(op_q)) begin
                        state_q <= ST_P_HI;
                    end else begin
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_P_HI: begin
                    res_q[2*DATA_W-1:DATA_W] <= alu_ans;
                    cy_q        <= alu_c_out;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ALU inputs are a pure decode of the pass in progress; zero otherwise.
    always_comb begin
        alu_op     = '0;
        alu_a_data = '0;
        alu_b_data = '0;
        alu_c_in   = 1'b0;
        case (state_q)
            ST_P_LO: begin
                alu_op     = op_q;
                alu_a_data = a_q[DATA_W-1:0];
                alu_b_data = b_q[DATA_W-1:0];
                alu_c_in   = cin_q;
            end
            ST_P_HI: begin
                alu_op     = hi_pass_op(op_q);
                alu_a_data = a_q[2*DATA_W-1:DATA_W];
                alu_b_data = b_q[2*DATA_W-1:DATA_W];
                alu_c_in   = cy_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_q;
    assign res_cy      = cy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a byte-level behavioural ALU beside it
// and a 16-bit arithmetic reference model for the expected results.
module tb_alu_seq;
    import mcu51_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_cin;
    logic        cmd_wide;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_cy;
    logic [4:0]  alu_op;
    logic [7:0]  alu_a_data;
    logic [7:0]  alu_b_data;
    logic        alu_c_in;
    logic [7:0]  alu_ans;
    logic        alu_c_out;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.DATA_W(8), .OP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .cmd_wide   (cmd_wide),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_cy     (res_cy),
        .alu_op     (alu_op),
        .alu_a_data (alu_a_data),
        .alu_b_data (alu_b_data),
        .alu_c_in   (alu_c_in),
        .alu_ans    (alu_ans),
        .alu_c_out  (alu_c_out),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU (byte wide).
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (alu_op)
            ALU_ADD:  t = {1'b0, alu_a_data} + {1'b0, alu_b_data};
            ALU_ADDC: t = {1'b0, alu_a_data} + {1'b0, alu_b_data} + {8'd0, alu_c_in};
            ALU_SUBB: t = {1'b0, alu_a_data} - {1'b0, alu_b_data} - {8'd0, alu_c_in};
            ALU_INC:  t = {1'b0, alu_a_data + 8'd1};
            ALU_DEC:  t = {1'b0, alu_a_data - 8'd1};
            ALU_ANL:  t = {1'b0, alu_a_data & alu_b_data};
            ALU_ORL:  t = {1'b0, alu_a_data | alu_b_data};
            ALU_XRL:  t = {1'b0, alu_a_data ^ alu_b_data};
            default:  t = 9'd0;
        endcase
        alu_ans   = t[7:0];
        alu_c_out = t[8];
    end

    // Reference: whole-command arithmetic on 8 or 16 bits.
    function automatic logic [16:0] ref_model(input logic [4:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin,
                                              input logic wide);
        logic [16:0] r;
        logic        w;
        w = wide && (op == ALU_ADD || op == ALU_ADDC || op == ALU_SUBB);
        if (!w) begin
            a = {8'd0, a[7:0]};
            b = {8'd0, b[7:0]};
        end
        case (op)
            ALU_ADD:  r = {1'b0, a} + {1'b0, b};
            ALU_ADDC: r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            ALU_SUBB: begin
                r[15:0] = a - b - {15'd0, cin};
                r[16]   = ({1'b0, a} < ({1'b0, b} + {16'd0, cin}));
            end
            ALU_INC:  r = {9'd0, a[7:0] + 8'd1};
            ALU_DEC:  r = {9'd0, a[7:0] - 8'd1};
            ALU_ANL:  r = {1'b0, a & b};
            ALU_ORL:  r = {1'b0, a | b};
            ALU_XRL:  r = {1'b0, a ^ b};
            default:  r = 17'd0;
        endcase
        if (!w) r = {r[8], 8'd0, r[7:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_data"}, {16'd0, res_data}, 32'd0);
        chk({tag, "_res_cy"}, {31'd0, res_cy}, 32'd0);
        chk({tag, "_alu_drive"}, {14'd0, alu_op, alu_a_data, alu_b_data, alu_c_in}, 32'd0);
    endtask

    // Called just after an edge with the DUT in IDLE; leaves it in IDLE.
    task automatic run_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic wide, input int hold, input logic early,
                           output logic [15:0] rd, output logic rc, output int lat);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_wide = wide;
        tick();
        lat = 1;
        cmd_valid = 1'b0;
        cmd_op = 5'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cmd_cin = 1'($urandom); cmd_wide = 1'($urandom);
        res_ready = early;
        while (!res_valid && lat < 10) begin
            tick();
            lat++;
        end
        res_ready = 1'b0;
        if (!res_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL res_valid_timeout: got 0 expected 1 within 10 cycles");
        end
        chk("done_alu_idle", {14'd0, alu_op, alu_a_data, alu_b_data, alu_c_in}, 32'd0);
        rd = res_data;
        rc = res_cy;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", {15'd0, res_cy, res_data}, {15'd0, rc, rd});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("post_accept_valid", {31'd0, res_valid}, 32'd0);
        chk("post_accept_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        wide;
        int          hold;
        logic [15:0] exp_data;
        logic        exp_cy;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] rd;
        logic        rc;
        int          lat;
        logic [16:0] exp;
        logic [4:0]  rops[8];

        vecs[0] = '{ALU_ADD,  16'h0045, 16'h0026, 1'b0, 1'b0, 0, 16'h006B, 1'b0, 2};
        vecs[1] = '{ALU_SUBB, 16'h0057, 16'h0012, 1'b0, 1'b0, 0, 16'h0045, 1'b0, 2};
        vecs[2] = '{ALU_ADDC, 16'h0075, 16'h0078, 1'b1, 1'b0, 0, 16'h00EE, 1'b0, 2};
        vecs[3] = '{ALU_ADD,  16'h12FF, 16'h0001, 1'b0, 1'b1, 0, 16'h1300, 1'b0, 3};
        vecs[4] = '{ALU_SUBB, 16'h1000, 16'h0001, 1'b0, 1'b1, 0, 16'h0FFF, 1'b0, 3};
        vecs[5] = '{ALU_ANL,  16'hF0F0, 16'hAAAA, 1'b0, 1'b1, 0, 16'h00A0, 1'b0, 2};
        vecs[6] = '{ALU_ADD,  16'h3456, 16'hABCD, 1'b0, 1'b0, 4, 16'h0023, 1'b1, 2};
        rops = '{ALU_ADD, ALU_ADDC, ALU_SUBB, ALU_INC, ALU_DEC, ALU_ANL, ALU_ORL, ALU_XRL};

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_wide = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_valid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].wide,
                    vecs[i].hold, 1'b0, rd, rc, lat);
            chk($sformatf("vec%0d_data", i), {16'd0, rd}, {16'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_cy", i), {31'd0, rc}, {31'd0, vecs[i].exp_cy});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Reset during the high pass drops the command.
        cmd_valid = 1'b1; cmd_op = ALU_ADD; cmd_a = 16'h12FF; cmd_b = 16'h0001;
        cmd_cin = 1'b0; cmd_wide = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_p_hi_state", {30'd0, dbg_state}, {30'd0, ST_P_HI});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_p_hi");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_result_after_rst", {31'd0, res_valid}, 32'd0);
        end

        // Reset beats a simultaneous command.
        rst = 1'b1; cmd_valid = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        tick();
        chk_reset_outputs("rst_with_cmd");

        run_cmd(ALU_ADD, 16'h0045, 16'h0026, 1'b0, 1'b0, 0, 1'b1, rd, rc, lat);
        chk("after_rst_data", {15'd0, rc, rd}, 32'h0000_006B);

        for (int i = 0; i < 60; i++) begin
            logic [4:0]  op;
            logic [15:0] a, b;
            logic        cin, wide;
            op = rops[$urandom_range(0, 7)];
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); wide = 1'($urandom);
            exp = ref_model(op, a, b, cin, wide);
            run_cmd(op, a, b, cin, wide, $urandom_range(0, 2), 1'($urandom), rd, rc, lat);
            chk($sformatf("rand%0d_op%0d_w%0d", i, op, wide), {15'd0, rc, rd}, {15'd0, exp});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
